// File: rtl/uart_rx_pkt_ctrl.sv
// UART receive packetizer: hunts for a sync byte, assembles MSB-first address
// and data fields, and presents each packet on a valid/ready handshake.
module uart_rx_pkt_ctrl #(
  parameter int unsigned             DATA_WIDTH   = 8,
  parameter int unsigned             ADDR_BYTES   = 2,
  parameter int unsigned             DATA_BYTES   = 1,
  parameter logic [DATA_WIDTH-1:0]   SYNC_BYTE    = 8'hA5,
  parameter int unsigned             TIMEOUT_CLKS = 320
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    rx_ready,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    pkt_valid,
  input  logic                    pkt_ready,
  output logic [8*ADDR_BYTES-1:0] pkt_addr,
  output logic [8*DATA_BYTES-1:0] pkt_data,
  output logic                    busy,
  output logic                    err_timeout,
  output logic                    err_overrun,
  input  logic                    err_clr
);

  localparam int unsigned AW   = 8 * ADDR_BYTES;
  localparam int unsigned DW   = 8 * DATA_BYTES;
  localparam int unsigned BMAX = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned BCW  = $clog2(BMAX) + 1;
  localparam int unsigned TCW  = $clog2(TIMEOUT_CLKS) + 1;

  localparam logic [BCW-1:0] ADDR_LAST = BCW'(ADDR_BYTES - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BYTES - 1);
  // Counter value from which one more idle clock reaches TIMEOUT_CLKS-1.
  localparam logic [TCW-1:0] TC_LAST   = TCW'(TIMEOUT_CLKS - 2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]     state;
  logic           rx_ready_q;
  logic [BCW-1:0] bcnt;
  logic [TCW-1:0] tcnt;
  logic           stb;
  logic [7:0]     rx_byte;
  logic           tc_hit;

  assign stb     = rx_ready & ~rx_ready_q;
  assign rx_byte = 8'(rx_data);
  assign tc_hit  = (tcnt == TC_LAST);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      rx_ready_q  <= 1'b1;
      pkt_valid   <= 1'b0;
      pkt_addr    <= '0;
      pkt_data    <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      bcnt        <= '0;
      tcnt        <= '0;
    end else begin
      rx_ready_q  <= rx_ready;
      err_timeout <= 1'b0;
      // Clear first so a same-cycle overrun in HOLD takes priority.
      if (err_clr)
        err_overrun <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (stb && (rx_data == SYNC_BYTE)) begin
            state <= ST_ADDR;
            bcnt  <= '0;
            tcnt  <= '0;
          end
        end

        ST_ADDR: begin
          if (stb) begin
            pkt_addr <= (pkt_addr << 8) | AW'(rx_byte);
            tcnt     <= '0;
            if (bcnt == ADDR_LAST) begin
              state <= ST_DATA;
              bcnt  <= '0;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end else if (tc_hit) begin
            state       <= ST_IDLE;
            err_timeout <= 1'b1;
            tcnt        <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (stb) begin
            pkt_data <= (pkt_data << 8) | DW'(rx_byte);
            tcnt     <= '0;
            if (bcnt == DATA_LAST) begin
              state     <= ST_HOLD;
              pkt_valid <= 1'b1;
              bcnt      <= '0;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end else if (tc_hit) begin
            state       <= ST_IDLE;
            err_timeout <= 1'b1;
            tcnt        <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        ST_HOLD: begin
          if (stb)
            err_overrun <= 1'b1;
          if (pkt_ready) begin
            pkt_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
- Sequences the UART receiver output into bus-command packets for the system bus master.
- Detects each completed byte from the receiver's ready/data pair and hunts for a sync byte.
- Assembles address and data fields MSB-first, then presents one packet on a valid/ready handshake.
- Guards against stalled frames with an inter-byte timeout, and flags bytes lost while a packet is held.

Parameters:
- DATA_WIDTH, 8: width of one received UART byte.
- ADDR_BYTES, 2: number of address bytes per packet (≥1).
- DATA_BYTES, 1: number of data bytes per packet (≥1).
- SYNC_BYTE, 8'hA5: packet start marker.
- TIMEOUT_CLKS, 320: maximum clocks allowed between bytes inside a packet (≥2).

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- rx_ready  input  1  receiver ready: high when idle, low during a frame, rises when a byte completes.
- rx_data  input  DATA_WIDTH  receiver byte; valid on and after the rx_ready rising edge.
- pkt_valid  output  1  packet available.
- pkt_ready  input  1  consumer accepts the packet.
- pkt_addr  output  8*ADDR_BYTES  assembled address.
- pkt_data  output  8*DATA_BYTES  assembled data.
- busy  output  1  high in ADDR, DATA or HOLD.
- err_timeout  output  1  one-cycle pulse when a partial packet is aborted.
- err_overrun  output  1  sticky flag: a byte was dropped in HOLD.
- err_clr  input  1  synchronous clear of err_overrun.

Behaviour:
- Reset (async, rstn low): state=IDLE, pkt_valid=0, pkt_addr=0, pkt_data=0, busy=0, err_timeout=0, err_overrun=0, byte counter=0, timeout counter=0, rx_ready_q=1.
- rx_ready_q resets to 1 because the receiver's ready is 1 out of reset; this prevents a false byte strobe.
- Byte strobe: stb = rx_ready & ~rx_ready_q, registered edge detect. Capture rx_data in the stb cycle.
- IDLE:
  - stb with rx_data==SYNC_BYTE -> ADDR, byte counter=0, timeout counter=0.
  - Any other byte is silently discarded.
- ADDR:
  - stb -> shift byte into pkt_addr from the LSB side (first byte ends up MSB), counter+1.
  - On byte ADDR_BYTES -> DATA, counter=0.
- DATA:
  - Same shift into pkt_data.
  - On byte DATA_BYTES -> HOLD, pkt_valid=1 from the next cycle.
- HOLD:
  - pkt_addr and pkt_data are held stable while pkt_valid=1.
  - pkt_valid&pkt_ready -> pkt_valid=0 next cycle, state=IDLE.
- Latency: pkt_valid rises 1 clock after the last data-byte strobe.
- Timeout:
  - In ADDR/DATA the counter increments on each non-stb clock and clears on stb.
  - When it reaches TIMEOUT_CLKS-1 without stb: -> IDLE, err_timeout=1 for one cycle, partial fields retain contents, pkt_valid stays 0.
- Simultaneous stb and timeout terminal count: stb wins. The byte is accepted and the counter clears.
- stb in HOLD, including the handshake cycle: byte dropped, err_overrun set to 1.
- err_clr=1 clears err_overrun. If stb-in-HOLD occurs in the same cycle, set wins.
- A SYNC_BYTE value received inside ADDR/DATA is treated as ordinary payload; no resync.
- busy = (state != IDLE), registered with the state.
- Reset mid-packet or in HOLD: immediate return to reset values; the held packet is lost.
- Counters are sized to clog2 of their terminal value plus 1; no wrap is possible before the terminal count.

Test Plan:
- Defaults. Bytes A5,12,34,56 with gaps of 160 clk, pkt_ready=1 -> pkt_valid high exactly 1 cycle, starting 1 clk after the 4th strobe; pkt_addr=16'h1234, pkt_data=8'h56; busy drops the cycle after the handshake.
- Bytes 00,FF,A5,AB,CD,EF -> leading 00/FF ignored; packet addr=16'hABCD, data=8'hEF.
- A5,12 then no byte for 320 clk -> err_timeout single pulse at clock 319 after the 12 strobe; state IDLE. Following A5,01,02,03 -> addr=16'h0102, data=8'h03.
- Complete packet with pkt_ready=0, then byte 77 -> err_overrun=1, pkt_data still 8'h56. Raise pkt_ready -> handshake; err_clr pulse -> err_overrun=0.
- Assert rstn=0 immediately after the first rx_ready rise out of reset, or after A5,12 -> no false strobe; all outputs return to 0 and no packet is emitted.
- Stb on exactly the timeout terminal-count clock -> byte accepted, no err_timeout pulse.
